// File: rtl/split_access_unit.sv
// split_access_unit: RISC-V load/store datapath between the memory stage and data memory.
// Define MISALIGNED_SPLIT_EN to split word-crossing accesses into two memory beats.
module split_access_unit #(
   parameter int XLEN       = 32,
   parameter int ADDR_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  memory_read,
   input  logic                  memory_write,
   input  logic [2:0]            funct3,
   input  logic [ADDR_WIDTH-1:0] address,
   input  logic [XLEN-1:0]       register_file_read_data,
   output logic                  resp_valid,
   output logic [XLEN-1:0]       register_file_write_data,
   output logic                  access_fault,
   output logic                  mem_req,
   output logic                  mem_write,
   output logic [ADDR_WIDTH-1:0] mem_address,
   output logic [XLEN-1:0]       mem_write_data,
   output logic [XLEN/8-1:0]     write_mask,
   input  logic [XLEN-1:0]       mem_read_data,
   input  logic                  mem_ack
);
   localparam int NB = XLEN / 8;
   localparam int OW = $clog2(NB);
`ifdef MISALIGNED_SPLIT_EN
   localparam int SPAN = 2;
`else
   localparam int SPAN = 1;
`endif

   typedef enum logic [1:0] {S_IDLE, S_BEAT0, S_BEAT1, S_RESP} state_t;
   state_t state_reg, state_next;

   logic [2:0]            f3_reg;
   logic [OW-1:0]         offset_reg;
   logic                  store_reg;
   logic                  fault_reg;
   logic [XLEN-1:0]       result_reg;
   logic [ADDR_WIDTH-1:0] mem_address_reg;
   logic                  mem_write_reg;
   logic [XLEN-1:0]       mem_write_data_reg;
   logic [NB-1:0]         write_mask_reg;
`ifdef MISALIGNED_SPLIT_EN
   logic                  split_reg;
   logic [XLEN-1:0]       wdata_hi_reg;
   logic [NB-1:0]         mask_hi_reg;
   logic [XLEN-1:0]       buf_lo_reg;
   logic                  in_split;
   logic                  last_beat;
`else
   logic                  in_misaligned;
`endif

   // Request decode, only meaningful while IDLE
   logic                  accept;
   logic [OW-1:0]         in_offset;
   logic                  in_store;
   logic                  in_unsupported;
   logic                  in_fault;
   logic [NB-1:0]         size_ones;
   logic [SPAN*XLEN-1:0]  store_cat;
   logic [SPAN*NB-1:0]    mask_cat;
   logic                  beat_done;

   assign accept         = req_valid && (state_reg == S_IDLE);
   assign in_offset      = address[OW-1:0];
   assign in_store       = memory_write && !memory_read;
   assign in_unsupported = (funct3 == 3'b111) || (int'(funct3[1:0]) > OW);
`ifdef MISALIGNED_SPLIT_EN
   assign in_split = (int'(in_offset) + (1 << funct3[1:0])) > NB;
   assign in_fault = in_unsupported;
`else
   assign in_misaligned = (in_offset & OW'((1 << funct3[1:0]) - 1)) != '0;
   assign in_fault      = in_unsupported || in_misaligned;
`endif

   genvar gi;
   generate
      for (gi = 0; gi < NB; gi++) begin : g_size_ones
         assign size_ones[gi] = gi < (1 << funct3[1:0]);
      end
   endgenerate

   // Lane placement over a double-width window; the upper half feeds the second beat
   assign store_cat = (SPAN*XLEN)'(register_file_read_data) << {in_offset, 3'b000};
   assign mask_cat  = (SPAN*NB)'(size_ones) << in_offset;

   logic [SPAN*XLEN-1:0] load_cat;
   logic [XLEN-1:0]      load_low;
   logic [XLEN-1:0]      load_keep;
   logic [XLEN-1:0]      load_ext;
   logic                 load_sign;

   always_comb begin
`ifdef MISALIGNED_SPLIT_EN
      load_cat = (state_reg == S_BEAT1) ? {mem_read_data, buf_lo_reg}
                                        : {{XLEN{1'b0}}, mem_read_data};
`else
      load_cat = mem_read_data;
`endif
      load_low = XLEN'(load_cat >> {offset_reg, 3'b000});
      case (f3_reg[1:0])
         2'd0: begin
            load_sign = load_low[7];
            load_keep = XLEN'(8'hFF);
         end
         2'd1: begin
            load_sign = load_low[15];
            load_keep = XLEN'(16'hFFFF);
         end
         2'd2: begin
            load_sign = load_low[31];
            load_keep = XLEN'(32'hFFFF_FFFF);
         end
         default: begin
            load_sign = load_low[XLEN-1];
            load_keep = '1;
         end
      endcase
      load_ext = (load_low & load_keep) | ((load_sign && !f3_reg[2]) ? ~load_keep : '0);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_reg <= S_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         S_IDLE: begin
            if (accept) begin
               state_next = in_fault ? S_RESP : S_BEAT0;
            end
         end
         S_BEAT0: begin
            if (mem_ack) begin
`ifdef MISALIGNED_SPLIT_EN
               state_next = split_reg ? S_BEAT1 : S_RESP;
`else
               state_next = S_RESP;
`endif
            end
         end
`ifdef MISALIGNED_SPLIT_EN
         S_BEAT1: begin
            if (mem_ack) begin
               state_next = S_RESP;
            end
         end
`endif
         S_RESP:  state_next = S_IDLE;
         default: state_next = S_IDLE;
      endcase
   end

   always_comb begin
      req_ready    = (state_reg == S_IDLE);
      resp_valid   = (state_reg == S_RESP);
      mem_req      = (state_reg == S_BEAT0) || (state_reg == S_BEAT1);
      access_fault = (state_reg == S_RESP) && fault_reg;
   end

   assign register_file_write_data = result_reg;
   assign mem_write                = mem_write_reg;
   assign mem_address              = mem_address_reg;
   assign mem_write_data           = mem_write_data_reg;
   assign write_mask               = write_mask_reg;

   assign beat_done = ((state_reg == S_BEAT0) || (state_reg == S_BEAT1)) && mem_ack;
`ifdef MISALIGNED_SPLIT_EN
   assign last_beat = (state_reg == S_BEAT1) || !split_reg;
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         f3_reg             <= '0;
         offset_reg         <= '0;
         store_reg          <= 1'b0;
         fault_reg          <= 1'b0;
         result_reg         <= '0;
         mem_address_reg    <= '0;
         mem_write_reg      <= 1'b0;
         mem_write_data_reg <= '0;
         write_mask_reg     <= '0;
`ifdef MISALIGNED_SPLIT_EN
         split_reg          <= 1'b0;
         wdata_hi_reg       <= '0;
         mask_hi_reg        <= '0;
         buf_lo_reg         <= '0;
`endif
      end else if (accept) begin
         f3_reg     <= funct3;
         offset_reg <= in_offset;
         store_reg  <= in_store;
         fault_reg  <= in_fault;
         result_reg <= '0;
`ifdef MISALIGNED_SPLIT_EN
         split_reg  <= in_split && !in_fault;
`endif
         if (!in_fault) begin
            mem_address_reg    <= {address[ADDR_WIDTH-1:OW], {OW{1'b0}}};
            mem_write_reg      <= in_store;
            mem_write_data_reg <= in_store ? store_cat[XLEN-1:0] : '0;
            write_mask_reg     <= in_store ? mask_cat[NB-1:0] : '0;
`ifdef MISALIGNED_SPLIT_EN
            wdata_hi_reg       <= in_store ? store_cat[2*XLEN-1:XLEN] : '0;
            mask_hi_reg        <= in_store ? mask_cat[2*NB-1:NB] : '0;
`endif
         end
      end else if (beat_done) begin
`ifdef MISALIGNED_SPLIT_EN
         if (last_beat) begin
            result_reg <= store_reg ? '0 : load_ext;
         end else begin
            // First half of a split: keep the low word, retarget the bus to the next word
            buf_lo_reg         <= mem_read_data;
            mem_address_reg    <= mem_address_reg + ADDR_WIDTH'(NB);
            mem_write_data_reg <= wdata_hi_reg;
            write_mask_reg     <= mask_hi_reg;
         end
`else
         result_reg <= store_reg ? '0 : load_ext;
`endif
      end else if (state_reg == S_RESP) begin
         result_reg <= '0;
      end
   end

endmodule
